// File: rtl/dmd_steal_arb_pkg.sv
// Shared definitions for the DMD cycle-steal arbiter.
// Round-robin arbitration is enabled by defining DMD_STEAL_RR_EN.
package dmd_steal_arb_pkg;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned WAIT_W = 8;

    localparam logic [1:0] SPT0 = 2'd0;
    localparam logic [1:0] SPT1 = 2'd1;
    localparam logic [1:0] IDMA = 2'd2;
    localparam logic [1:0] BDMA = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_XFER = 2'd2
    } state_e;

    // Encode a one-hot requester vector into its index.
    function automatic logic [1:0] oh2idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dmd_steal_arb_pick.sv
// Winner selection: first requester found searching upward
// from the pointer, wrapping. Pointer 0 gives fixed priority.
module dsa_pick
    import dmd_steal_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    // Rotating search starting at ptr_i.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        gnt_o = '0;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr_i + 2'(i);
            if (req_i[idx] && !found) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmd_steal_arb.sv
// DMD cycle-steal arbiter: IDLE -> ARB -> XFER handshake with core.
// Define DMD_STEAL_RR_EN for round-robin instead of fixed priority.
module dmd_steal_arb
    import dmd_steal_arb_pkg::*;
(
    input  logic              DSPCLK,
    input  logic              RSTn,
    input  logic              idma_req,
    input  logic              spt0_req,
    input  logic              spt1_req,
    input  logic              bdma_req,
    input  logic              GO_Cx,
    output logic              SREQ,
    output logic              idmaDMD_oe,
    output logic              spt0DMD_oe,
    output logic              spt1DMD_oe,
    output logic              bdmaDMD_oe,
    output logic              idma_ack,
    output logic              spt0_ack,
    output logic              spt1_ack,
    output logic              bdma_ack,
    output logic [WAIT_W-1:0] steal_wait
);

    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    state_e            state_q;
    logic [NREQ-1:0]   win_q;
    logic [NREQ-1:0]   oe_q;
    logic [NREQ-1:0]   ack_q;
    logic              sreq_q;
    logic [WAIT_W-1:0] wait_q;

    logic [NREQ-1:0]   req_v;
    logic [NREQ-1:0]   req_pick;
    logic [NREQ-1:0]   gnt;
    logic [1:0]        ptr;
    logic              win_live;
    logic              grant_fire;

    assign req_v      = {bdma_req, idma_req, spt1_req, spt0_req};
    assign win_live   = |(req_v & win_q);
    assign grant_fire = (state_q == S_ARB) && win_live && GO_Cx;

    // The requester just acked is excluded from the XFER re-arbitration.
    assign req_pick = (state_q == S_XFER) ? (req_v & ~win_q) : req_v;

`ifdef DMD_STEAL_RR_EN
    logic [1:0] ptr_q;

    // Pointer moves past the winner only when a grant completes.
    always_ff @(posedge DSPCLK or negedge RSTn) begin
        if (!RSTn) begin
            ptr_q <= SPT0;
        end else if (grant_fire) begin
            ptr_q <= oh2idx(win_q) + 2'd1;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = SPT0;
`endif

    dsa_pick u_pick (
        .req_i (req_pick),
        .ptr_i (ptr),
        .gnt_o (gnt)
    );

    // Steal FSM with registered SREQ, oe, ack and wait counter.
    always_ff @(posedge DSPCLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            oe_q    <= '0;
            ack_q   <= '0;
            sreq_q  <= 1'b0;
            wait_q  <= '0;
        end else begin
            oe_q  <= '0;
            ack_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (|gnt) begin
                        win_q   <= gnt;
                        state_q <= S_ARB;
                        sreq_q  <= 1'b1;
                        wait_q  <= '0;
                    end
                end
                S_ARB: begin
                    if (!win_live) begin
                        state_q <= S_IDLE;
                        sreq_q  <= 1'b0;
                    end else if (GO_Cx) begin
                        state_q <= S_XFER;
                        oe_q    <= win_q;
                        ack_q   <= win_q;
                    end else if (wait_q != WAIT_MAX) begin
                        wait_q <= wait_q + WAIT_ONE;
                    end
                end
                S_XFER: begin
                    if (|gnt) begin
                        win_q   <= gnt;
                        state_q <= S_ARB;
                        wait_q  <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        sreq_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    sreq_q  <= 1'b0;
                end
            endcase
        end
    end

    assign SREQ       = sreq_q;
    assign spt0DMD_oe = oe_q[SPT0];
    assign spt1DMD_oe = oe_q[SPT1];
    assign idmaDMD_oe = oe_q[IDMA];
    assign bdmaDMD_oe = oe_q[BDMA];
    assign spt0_ack   = ack_q[SPT0];
    assign spt1_ack   = ack_q[SPT1];
    assign idma_ack   = ack_q[IDMA];
    assign bdma_ack   = ack_q[BDMA];
    assign steal_wait = wait_q;

endmodule

// File: tb/tb_dmd_steal_arb.sv
// Directed self-checking bench for dmd_steal_arb.
// Vectors hold in both the fixed-priority and round-robin builds.
module tb_dmd_steal_arb;

    logic       DSPCLK = 1'b0;
    logic       RSTn   = 1'b0;
    logic       idma_req = 1'b0;
    logic       spt0_req = 1'b0;
    logic       spt1_req = 1'b0;
    logic       bdma_req = 1'b0;
    logic       GO_Cx    = 1'b0;
    logic       SREQ;
    logic       idmaDMD_oe, spt0DMD_oe, spt1DMD_oe, bdmaDMD_oe;
    logic       idma_ack, spt0_ack, spt1_ack, bdma_ack;
    logic [7:0] steal_wait;

    logic [3:0] oe_v;
    logic [3:0] ack_v;

    int n_chk  = 0;
    int n_pass = 0;

    assign oe_v  = {bdmaDMD_oe, idmaDMD_oe, spt1DMD_oe, spt0DMD_oe};
    assign ack_v = {bdma_ack, idma_ack, spt1_ack, spt0_ack};

    dmd_steal_arb dut (
        .DSPCLK     (DSPCLK),
        .RSTn       (RSTn),
        .idma_req   (idma_req),
        .spt0_req   (spt0_req),
        .spt1_req   (spt1_req),
        .bdma_req   (bdma_req),
        .GO_Cx      (GO_Cx),
        .SREQ       (SREQ),
        .idmaDMD_oe (idmaDMD_oe),
        .spt0DMD_oe (spt0DMD_oe),
        .spt1DMD_oe (spt1DMD_oe),
        .bdmaDMD_oe (bdmaDMD_oe),
        .idma_ack   (idma_ack),
        .spt0_ack   (spt0_ack),
        .spt1_ack   (spt1_ack),
        .bdma_ack   (bdma_ack),
        .steal_wait (steal_wait)
    );

    always #5 DSPCLK = ~DSPCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge DSPCLK);
        #1;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        {idma_req, spt0_req, spt1_req, bdma_req, GO_Cx} = '0;
        step();
        step();
        RSTn = 1'b1;
    endtask

    task automatic set_req(input logic [3:0] v);
        {bdma_req, idma_req, spt1_req, spt0_req} = v;
    endtask

    task automatic drop_req(input logic [3:0] v);
        {bdma_req, idma_req, spt1_req, spt0_req} =
            {bdma_req, idma_req, spt1_req, spt0_req} & ~v;
    endtask

    // Run until n grants are seen; requesters drop on ack if asked.
    task automatic collect(input int n, input bit drop,
                           output logic [3:0] g [8], output int got,
                           output int sreq_lo);
        got     = 0;
        sreq_lo = 0;
        for (int c = 0; c < 40 && got < n; c++) begin
            step();
            if (!SREQ) sreq_lo++;
            if (oe_v != 4'b0) begin
                if (got < 8) g[got] = oe_v;
                got++;
                if (drop) drop_req(ack_v);
            end
        end
    endtask

    initial begin
        logic [3:0] g [8];
        int         got;
        int         sreq_lo;
        int         pulses;

        // Reset state
        do_reset();
        chk("rst_sreq", 32'(SREQ), 0);
        chk("rst_oe", 32'(oe_v), 0);
        chk("rst_ack", 32'(ack_v), 0);
        chk("rst_wait", 32'(steal_wait), 0);

        // Single request on spt1 with GO held
        set_req(4'b0010);
        GO_Cx = 1'b1;
        step();
        chk("s1_sreq_e1", 32'(SREQ), 1);
        chk("s1_oe_e1", 32'(oe_v), 0);
        step();
        chk("s1_oe_e2", 32'(oe_v), 32'b0010);
        chk("s1_ack_e2", 32'(ack_v), 32'b0010);
        chk("s1_wait_e2", 32'(steal_wait), 0);
        drop_req(4'b0010);
        step();
        chk("s1_oe_e3", 32'(oe_v), 0);
        chk("s1_ack_e3", 32'(ack_v), 0);
        chk("s1_sreq_e3", 32'(SREQ), 0);

        // Four-way contention, requests drop on ack
        do_reset();
        set_req(4'b1111);
        GO_Cx = 1'b1;
        collect(4, 1'b1, g, got, sreq_lo);
        chk("ct_count", 32'(got), 4);
        chk("ct_g0", 32'(g[0]), 32'b0001);
        chk("ct_g1", 32'(g[1]), 32'b0010);
        chk("ct_g2", 32'(g[2]), 32'b0100);
        chk("ct_g3", 32'(g[3]), 32'b1000);
        chk("ct_sreq_hi", 32'(sreq_lo), 0);
        step();
        chk("ct_sreq_end", 32'(SREQ), 0);

        // idma and spt0 held continuously: grants alternate
        do_reset();
        set_req(4'b0101);
        GO_Cx = 1'b1;
        collect(6, 1'b0, g, got, sreq_lo);
        chk("alt_count", 32'(got), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("alt_g%0d", i), 32'(g[i]),
                (i % 2 == 0) ? 32'b0001 : 32'b0100);
        end

        // Wait counter saturation on bdma
        do_reset();
        set_req(4'b1000);
        GO_Cx = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("sat_wait10", 32'(steal_wait), 9);
        pulses = 0;
        for (int i = 10; i < 300; i++) begin
            step();
            if (oe_v != 4'b0) pulses++;
        end
        chk("sat_wait", 32'(steal_wait), 255);
        chk("sat_sreq", 32'(SREQ), 1);
        GO_Cx = 1'b1;
        step();
        if (oe_v != 4'b0) pulses++;
        chk("sat_oe", 32'(oe_v), 32'b1000);
        chk("sat_hold_xfer", 32'(steal_wait), 255);
        drop_req(4'b1000);
        for (int i = 0; i < 3; i++) begin
            step();
            if (oe_v != 4'b0) pulses++;
        end
        chk("sat_pulses", 32'(pulses), 1);
        chk("sat_hold_idle", 32'(steal_wait), 255);

        // Abort: idma dropped while waiting in ARB
        do_reset();
        set_req(4'b0100);
        GO_Cx = 1'b0;
        step();
        chk("ab_sreq", 32'(SREQ), 1);
        for (int i = 0; i < 3; i++) step();
        chk("ab_wait", 32'(steal_wait), 3);
        drop_req(4'b0100);
        GO_Cx = 1'b1;
        step();
        chk("ab_sreq_lo", 32'(SREQ), 0);
        chk("ab_oe", 32'(oe_v), 0);
        chk("ab_ack", 32'(ack_v), 0);
        set_req(4'b0101);
        collect(1, 1'b1, g, got, sreq_lo);
        chk("ab_next_cnt", 32'(got), 1);
        chk("ab_next_g", 32'(g[0]), 32'b0001);
        set_req(4'b0000);
        step();
        step();

        // Reset asserted during an spt0 transfer
        do_reset();
        set_req(4'b0001);
        GO_Cx = 1'b1;
        step();
        step();
        chk("rx_oe", 32'(oe_v), 32'b0001);
        #2;
        RSTn = 1'b0;
        #1;
        chk("rx_sreq", 32'(SREQ), 0);
        chk("rx_oe0", 32'(oe_v), 0);
        chk("rx_ack0", 32'(ack_v), 0);
        chk("rx_wait0", 32'(steal_wait), 0);
        #1;
        RSTn = 1'b1;
        step();
        chk("rx_arb_sreq", 32'(SREQ), 1);
        chk("rx_arb_oe", 32'(oe_v), 0);
        step();
        chk("rx_re_oe", 32'(oe_v), 32'b0001);
        chk("rx_re_ack", 32'(ack_v), 32'b0001);
        set_req(4'b0000);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
